output_deskew: RTL
==================

// Module: output_deskew
// PURPOSE
//  Receiving end of the 2x2 systolic array datapath: undoes the diagonal skew applied to activations at the array input.
//  Column partial-sum outputs leave the array bottom staggered by one cycle per row/column.
//  This block captures them over 2N-1 = 3 cycles and presents the aligned result matrix C[2][2].
//  Output uses a valid/ready hold handshake toward the host/unified buffer writeback.
// PARAMETERS
//  DATA_W   16   width of each array column output and each result element (no growth, no saturation)
//  CNT_W     8   width of completed-matrix counter (wraps)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state and outputs
//  in_first   in   1        pulse: col1_in carries c11 this cycle (first skewed output of a matrix)
//  col1_in    in   DATA_W   bottom output of array column 1 (c11 then c21)
//  col2_in    in   DATA_W   bottom output of array column 2 (c12 then c22)
//  out_ready  in   1        consumer accepts held matrix when high with out_valid
//  out_valid  out  1        c11..c22 hold a complete aligned matrix
//  c11,c12    out  DATA_W   result row 1
//  c21,c22    out  DATA_W   result row 2
//  overflow   out  1        sticky: an in_first was dropped
//  mat_count  out  CNT_W    number of matrices accepted by consumer, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; c11..c22=0; overflow=0; mat_count=0. Reset mid-capture discards partial matrix.
//  Skew timing, in_first at edge T: col1=c11 @T; col1=c21, col2=c12 @T+1; col2=c22 @T+2.
//  FSM states IDLE, CAP1, CAP2, HOLD (all regs update on posedge clk):
//   IDLE: in_first -> c11<=col1_in, go CAP1; else stay.
//   CAP1: c21<=col1_in, c12<=col2_in, go CAP2 (unconditional).
//   CAP2: c22<=col2_in, out_valid<=1, go HOLD (unconditional).
//   HOLD: out_valid=1, c11..c22 stable.
//    out_ready=1: handshake; mat_count<=mat_count+1.
//     If in_first also high: c11<=col1_in, out_valid<=0, go CAP1 (back-to-back, no bubble).
//     Otherwise out_valid<=0, go IDLE.
//    out_ready=0: stay; in_first -> overflow<=1, input dropped.
//  Latency: in_first at T -> out_valid high from T+3 (after edge ending CAP2).
//  in_first in CAP1/CAP2: ignored, overflow<=1, capture continues unaffected.
//  Every output is a register; no combinational path from inputs to outputs.
//  c11..c22 change only on capture writes; while out_valid=1 they are constant.
//  overflow is cleared only by reset.
//  mat_count increments only on an out_valid & out_ready handshake.
//  col*_in values are don't-care outside capture cycles.
// TESTING
//  1 Reset then idle 5 cycles -> out_valid=0, all c*=0, overflow=0, mat_count=0.
//  2 in_first@T, col1=5@T, col1=7/col2=6@T+1, col2=8@T+2, out_ready=1 -> out_valid=1 @T+3 with
//    c11=5 c12=6 c21=7 c22=8; drops at T+4; mat_count=1.
//  3 Same matrix with out_ready=0 for 4 cycles -> values held stable;
//    out_ready=1 -> one handshake, mat_count+1, state IDLE.
//  4 Back-to-back: second in_first in HOLD cycle with out_ready=1 -> next matrix
//    {1,2,3,4} captured without bubble, overflow=0.
//  5 in_first during CAP1, and during HOLD with out_ready=0 -> overflow=1 (sticky);
//    first matrix still correct.
//  6 Assert reset at T+1 mid-capture -> all outputs 0, state IDLE;
//    following clean matrix {9,10,11,12} captured correctly.
//    255 handshakes at CNT_W=8 -> mat_count wraps to 0 on the 256th.

Source files
------------

// File: rtl/output_deskew.sv
// Output deskew for the 2x2 systolic array: realigns staggered column
// outputs into a held C[2][2] matrix behind a valid/ready handshake.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   in_first          col1_in carries c11 this cycle (start of a matrix)
//   col1_in, col2_in  bottom outputs of array columns 1 and 2
//   out_ready         consumer accepts the held matrix
//   out_valid         c11..c22 hold a complete aligned matrix
//   c11..c22          result elements
//   overflow          sticky: an in_first arrived while busy and was dropped
//   mat_count         matrices accepted by the consumer (wraps)
module output_deskew #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_first,
    input  logic [DATA_W-1:0] col1_in,
    input  logic [DATA_W-1:0] col2_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] c11,
    output logic [DATA_W-1:0] c12,
    output logic [DATA_W-1:0] c21,
    output logic [DATA_W-1:0] c22,
    output logic              overflow,
    output logic [CNT_W-1:0]  mat_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CAP1 = 2'd1;
    localparam logic [1:0] CAP2 = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            c11       <= '0;
            c12       <= '0;
            c21       <= '0;
            c22       <= '0;
            overflow  <= 1'b0;
            mat_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_first) begin
                        c11   <= col1_in;
                        state <= CAP1;
                    end
                end
                CAP1: begin
                    c21   <= col1_in;
                    c12   <= col2_in;
                    state <= CAP2;
                    if (in_first)
                        overflow <= 1'b1;
                end
                CAP2: begin
                    c22       <= col2_in;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                    if (in_first)
                        overflow <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        mat_count <= mat_count + CNT_W'(1);
                        out_valid <= 1'b0;
                        // A new matrix may start on the accepting edge,
                        // so back-to-back matrices need no idle cycle.
                        if (in_first) begin
                            c11   <= col1_in;
                            state <= CAP1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (in_first) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
